// File: rtl/icache_controller_if.sv
// rtl/icache_controller_if.sv - fetch, instruction, cache and memory signals of the icache controller
interface icache_controller_if;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        cache_wr;
    logic        cache_waiting;
    logic [31:0] cache_addr;
    logic [31:0] cache_value;
    logic        cache_hit;
    logic [31:0] cache_result;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;

    // Environment side: fetch stage, cache array and memory controller
    modport master (
        output fetch_valid, fetch_pc, cache_hit, cache_result, mem_done, mem_data,
        input  fetch_ready, inst_valid, inst_out, inst_pc, cache_wr, cache_waiting,
               cache_addr, cache_value, mem_req, mem_addr
    );

    // Controller side
    modport slave (
        input  fetch_valid, fetch_pc, cache_hit, cache_result, mem_done, mem_data,
        output fetch_ready, inst_valid, inst_out, inst_pc, cache_wr, cache_waiting,
               cache_addr, cache_value, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_controller.sv
// rtl/icache_controller.sv - fetch/cache/memory sequencer; optional hit/miss counters under ICACHE_STATS_EN
module icache_controller #(
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush,
    icache_controller_if.slave    bus,
    output logic [STAT_WIDTH-1:0] hit_count,
    output logic [STAT_WIDTH-1:0] miss_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_q;
    logic [31:0] data_q;
    logic        killed_q;
    logic        valid_q;
    logic        valid_nxt;
    logic [31:0] inst_out_q;
    logic [31:0] inst_pc_q;
    logic        mem_req_q;
    logic        accept;
    logic        accept_hit;
    logic        accept_miss;

    // Acceptance and the combinational cache-facing outputs
    always_comb begin
        accept      = (state == IDLE) && rdy_in && !flush && bus.fetch_valid;
        accept_hit  = accept && bus.cache_hit;
        accept_miss = accept && !bus.cache_hit;
    end

    assign bus.fetch_ready   = (state == IDLE) && rdy_in && !flush;
    assign bus.cache_waiting = (state == IDLE) && !bus.fetch_valid;
    assign bus.cache_addr    = (state == IDLE) ? bus.fetch_pc : pc_q;
    assign bus.cache_value   = data_q;
    assign bus.cache_wr      = (state == FILL) && rdy_in;
    assign bus.mem_req       = mem_req_q;
    assign bus.mem_addr      = pc_q;
    assign bus.inst_out      = inst_out_q;
    assign bus.inst_pc       = inst_pc_q;
    // A response produced while stalled is held in valid_q and shown once rdy_in returns
    assign bus.inst_valid    = valid_q && rdy_in;

    // Next-state and next-response decode
    always_comb begin
        state_nxt = state;
        valid_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (accept_hit) begin
                    valid_nxt = 1'b1;
                end else if (accept_miss) begin
                    state_nxt = MISS;
                end
            end
            MISS: begin
                if (bus.mem_done) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                state_nxt = IDLE;
                valid_nxt = !killed_q && !flush;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register, frozen while rdy_in is low
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else if (rdy_in) begin
            state <= state_nxt;
        end
    end

    // Datapath registers: miss address, fill data, kill flag and response
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pc_q       <= 32'd0;
            data_q     <= 32'd0;
            killed_q   <= 1'b0;
            valid_q    <= 1'b0;
            inst_out_q <= 32'd0;
            inst_pc_q  <= 32'd0;
            mem_req_q  <= 1'b0;
        end else if (rdy_in) begin
            valid_q   <= valid_nxt;
            mem_req_q <= (state_nxt == MISS);
            if (accept_hit) begin
                inst_out_q <= bus.cache_result;
                inst_pc_q  <= bus.fetch_pc;
            end
            if (accept_miss) begin
                pc_q     <= bus.fetch_pc;
                killed_q <= 1'b0;
            end
            if (state == MISS) begin
                // The memory read still completes and fills the cache after a kill
                if (flush) begin
                    killed_q <= 1'b1;
                end
                if (bus.mem_done) begin
                    data_q <= bus.mem_data;
                end
            end
            if ((state == FILL) && valid_nxt) begin
                inst_out_q <= data_q;
                inst_pc_q  <= pc_q;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic [STAT_WIDTH-1:0] hit_q;
    logic [STAT_WIDTH-1:0] miss_q;

    // Acceptance counters; a later flush does not undo a count
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (accept_hit) begin
                hit_q <= hit_q + STAT_WIDTH'(1);
            end
            if (accept_miss) begin
                miss_q <= miss_q + STAT_WIDTH'(1);
            end
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_controller.sv
// tb/tb_icache_controller.sv - scoreboard bench for icache_controller
module tb_icache_controller;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache_controller_if bus();

    icache_controller #(.STAT_WIDTH(32)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .flush      (flush),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk_in = ~clk_in;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] inst_q[$];
    logic [63:0] wr_q[$];
    logic [31:0] hit_pcs[3];
    logic [31:0] hit_data[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] stat(input logic [31:0] v);
`ifdef ICACHE_STATS_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_in);
    endtask

    // Monitor: every response pulse and cache write is matched against the scoreboard
    always @(negedge clk_in) begin
        logic [63:0] e;
        if (!rst_in && bus.inst_valid) begin
            if (inst_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL inst_unexpected: got pulse pc 0x%08h, expected none", bus.inst_pc);
            end else begin
                e = inst_q.pop_front();
                check("inst_pc", bus.inst_pc, e[63:32]);
                check("inst_out", bus.inst_out, e[31:0]);
            end
        end
        if (!rst_in && bus.cache_wr) begin
            if (wr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL cache_wr_unexpected: got write addr 0x%08h, expected none", bus.cache_addr);
            end else begin
                e = wr_q.pop_front();
                check("cache_addr", bus.cache_addr, e[63:32]);
                check("cache_value", bus.cache_value, e[31:0]);
            end
        end
    end

    initial begin
        hit_pcs  = '{32'h10, 32'h14, 32'h18};
        hit_data = '{32'h0051_3023, 32'h00a0_0093, 32'hfe01_0113};
        rst_in = 1'b1;
        rdy_in = 1'b1;
        flush  = 1'b0;
        bus.fetch_valid  = 1'b0;
        bus.fetch_pc     = 32'd0;
        bus.cache_hit    = 1'b0;
        bus.cache_result = 32'd0;
        bus.mem_done     = 1'b0;
        bus.mem_data     = 32'd0;

        // Reset state
        cyc();
        cyc();
        mid();
        check("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("rst_inst_out", bus.inst_out, 32'd0);
        check("rst_inst_pc", bus.inst_pc, 32'd0);
        check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_cache_wr", {31'd0, bus.cache_wr}, 32'd0);
        check("rst_cache_waiting", {31'd0, bus.cache_waiting}, 32'd1);
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
        cyc();
        rst_in = 1'b0;

        // Cold miss with mem_done four cycles after accept
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = 32'h10;
        bus.cache_hit   = 1'b0;
        inst_q.push_back({32'h10, 32'h0051_3023});
        wr_q.push_back({32'h10, 32'h0051_3023});
        mid();
        check("cold_fetch_ready", {31'd0, bus.fetch_ready}, 32'd1);
        check("cold_cache_waiting", {31'd0, bus.cache_waiting}, 32'd0);
        cyc();
        bus.fetch_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            mid();
            check("cold_mem_req", {31'd0, bus.mem_req}, 32'd1);
            check("cold_mem_addr", bus.mem_addr, 32'h10);
            check("cold_fetch_ready_busy", {31'd0, bus.fetch_ready}, 32'd0);
            cyc();
        end
        bus.mem_done = 1'b1;
        bus.mem_data = 32'h0051_3023;
        mid();
        check("cold_mem_req_done", {31'd0, bus.mem_req}, 32'd1);
        cyc();
        bus.mem_done = 1'b0;
        bus.mem_data = 32'd0;
        mid();
        check("cold_fill_wr", {31'd0, bus.cache_wr}, 32'd1);
        check("cold_fill_mem_req", {31'd0, bus.mem_req}, 32'd0);
        cyc();
        mid();
        check("cold_inst_valid", {31'd0, bus.inst_valid}, 32'd1);
        check("cold_fetch_ready_back", {31'd0, bus.fetch_ready}, 32'd1);
        check("cold_miss_count", miss_count, stat(32'd1));
        cyc();

        // Back-to-back hits
        for (int i = 0; i < 3; i++) begin
            bus.fetch_valid  = 1'b1;
            bus.fetch_pc     = hit_pcs[i];
            bus.cache_hit    = 1'b1;
            bus.cache_result = hit_data[i];
            inst_q.push_back({hit_pcs[i], hit_data[i]});
            mid();
            check("hit_fetch_ready", {31'd0, bus.fetch_ready}, 32'd1);
            if (i > 0) begin
                check("hit_stream_valid", {31'd0, bus.inst_valid}, 32'd1);
                check("hit_stream_pc", bus.inst_pc, hit_pcs[i-1]);
            end
            cyc();
        end
        bus.fetch_valid = 1'b0;
        bus.cache_hit   = 1'b0;
        mid();
        check("hit_last_valid", {31'd0, bus.inst_valid}, 32'd1);
        check("hit_last_pc", bus.inst_pc, 32'h18);
        check("hit_count_3", hit_count, stat(32'd3));
        cyc();
        mid();
        check("hit_idle_valid", {31'd0, bus.inst_valid}, 32'd0);
        cyc();

        // Flush one cycle after a miss accept
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = 32'h20;
        wr_q.push_back({32'h20, 32'h1111_1111});
        mid();
        cyc();
        bus.fetch_valid = 1'b0;
        flush = 1'b1;
        mid();
        check("fl_miss_mem_req", {31'd0, bus.mem_req}, 32'd1);
        cyc();
        flush = 1'b0;
        mid();
        check("fl_miss_mem_req_hold", {31'd0, bus.mem_req}, 32'd1);
        check("fl_miss_mem_addr", bus.mem_addr, 32'h20);
        cyc();
        bus.mem_done = 1'b1;
        bus.mem_data = 32'h1111_1111;
        mid();
        cyc();
        bus.mem_done = 1'b0;
        mid();
        check("fl_miss_cache_wr", {31'd0, bus.cache_wr}, 32'd1);
        cyc();
        mid();
        check("fl_miss_no_inst", {31'd0, bus.inst_valid}, 32'd0);
        check("fl_miss_idle", {31'd0, bus.fetch_ready}, 32'd1);
        cyc();

        // Flush coincident with the earliest mem_done
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = 32'h24;
        wr_q.push_back({32'h24, 32'h2222_2222});
        mid();
        cyc();
        bus.fetch_valid = 1'b0;
        bus.mem_done    = 1'b1;
        bus.mem_data    = 32'h2222_2222;
        flush           = 1'b1;
        mid();
        check("fl_done_mem_req", {31'd0, bus.mem_req}, 32'd1);
        cyc();
        bus.mem_done = 1'b0;
        flush        = 1'b0;
        mid();
        check("fl_done_cache_wr", {31'd0, bus.cache_wr}, 32'd1);
        cyc();
        mid();
        check("fl_done_no_inst", {31'd0, bus.inst_valid}, 32'd0);
        cyc();

        // Flush during FILL
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = 32'h28;
        wr_q.push_back({32'h28, 32'h3333_3333});
        mid();
        cyc();
        bus.fetch_valid = 1'b0;
        bus.mem_done    = 1'b1;
        bus.mem_data    = 32'h3333_3333;
        mid();
        cyc();
        bus.mem_done = 1'b0;
        flush        = 1'b1;
        mid();
        check("fl_fill_cache_wr", {31'd0, bus.cache_wr}, 32'd1);
        cyc();
        flush = 1'b0;
        mid();
        check("fl_fill_no_inst", {31'd0, bus.inst_valid}, 32'd0);
        check("fl_fill_idle", {31'd0, bus.fetch_ready}, 32'd1);
        cyc();

        // rdy_in low for three cycles between a hit accept and its response
        bus.fetch_valid  = 1'b1;
        bus.fetch_pc     = 32'h30;
        bus.cache_hit    = 1'b1;
        bus.cache_result = 32'h4444_4444;
        inst_q.push_back({32'h30, 32'h4444_4444});
        mid();
        check("stall_accept", {31'd0, bus.fetch_ready}, 32'd1);
        cyc();
        bus.fetch_valid = 1'b0;
        bus.cache_hit   = 1'b0;
        rdy_in          = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            check("stall_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
            check("stall_fetch_ready", {31'd0, bus.fetch_ready}, 32'd0);
            cyc();
        end
        rdy_in = 1'b1;
        mid();
        check("stall_release_valid", {31'd0, bus.inst_valid}, 32'd1);
        check("stall_release_pc", bus.inst_pc, 32'h30);
        cyc();
        mid();
        check("stall_single_pulse", {31'd0, bus.inst_valid}, 32'd0);
        check("stall_hit_count", hit_count, stat(32'd4));
        check("stall_miss_count", miss_count, stat(32'd4));
        cyc();

        // Reset during MISS; the abandoned miss produces nothing
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = 32'h40;
        mid();
        cyc();
        bus.fetch_valid = 1'b0;
        rst_in          = 1'b1;
        mid();
        check("rstm_mem_req_before", {31'd0, bus.mem_req}, 32'd1);
        cyc();
        rst_in           = 1'b0;
        bus.fetch_valid  = 1'b1;
        bus.fetch_pc     = 32'h44;
        bus.cache_hit    = 1'b1;
        bus.cache_result = 32'h5555_5555;
        inst_q.push_back({32'h44, 32'h5555_5555});
        mid();
        check("rstm_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rstm_hit_count", hit_count, 32'd0);
        check("rstm_miss_count", miss_count, 32'd0);
        check("rstm_fetch_ready", {31'd0, bus.fetch_ready}, 32'd1);
        cyc();
        bus.fetch_valid = 1'b0;
        bus.cache_hit   = 1'b0;
        mid();
        check("rstm_inst_valid", {31'd0, bus.inst_valid}, 32'd1);
        check("rstm_inst_pc", bus.inst_pc, 32'h44);
        check("rstm_hit_after", hit_count, stat(32'd1));
        cyc();
        cyc();
        mid();
        check("inst_queue_drained", inst_q.size(), 32'd0);
        check("wr_queue_drained", wr_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
